// File: rtl/lock_pkg.sv
// lock_pkg: shared state type and lock command codes for the round-robin accelerator lock
package lock_pkg;
  typedef enum logic [1:0] {IDLE, LOCKED, FLUSH} lock_state_e;
  localparam int CMD_ACQUIRE = 1;
  localparam int CMD_RELEASE = 0;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin pick of the first requester after last (mod N)
module rr_picker #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);
  logic [IW:0] sh;
  logic [N-1:0] rot;
  int p;
  assign sh = {1'b0, last} + (IW+1)'(1);
  assign rot = N'({req, req} >> sh);
  always_comb begin
    p = 0;
    for (int k = N-1; k >= 0; k--) p = rot[k] ? k : p;
  end
  assign gnt_valid = |req;
  assign gnt_idx = IW'((p + int'(sh)) % N);
endmodule

// File: rtl/lock_arbiter_rr.sv
// lock_arbiter_rr: software lock sharing one accelerator among N cores, with
// round-robin grants, an idle-owner watchdog and a post-release accelerator reset.
module lock_arbiter_rr
  import lock_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] LOCK_ADDR = 'd84,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 'd88,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RST_CYC = 4,
  localparam int OW = $clog2(N_CLIENTS+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in [N_CLIENTS],
  input  logic              wr_en_in [N_CLIENTS],
  input  logic              select_in [N_CLIENTS],
  input  logic [DATA_W-1:0] data_in [N_CLIENTS],
  output logic [DATA_W-1:0] data_out [N_CLIENTS],
  input  logic [DATA_W-1:0] data_from_accel,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_to_accel,
  output logic              wr_en_o,
  output logic              accel_select_o,
  output logic              accel_rst_o,
  output logic [OW-1:0]     owner_o
);
  localparam int IW = $clog2(N_CLIENTS);
  localparam int FW = $clog2(RST_CYC+1);
  localparam logic [OW-1:0] FREE = OW'(N_CLIENTS);
  lock_state_e state;
  logic [OW-1:0] owner;
  logic [IW-1:0] last_owner, oi, gnt_idx;
  logic [31:0] timer;
  logic [FW-1:0] flush_cnt;
  logic [N_CLIENTS-1:0] acq, rel, stat_wr, tmo_flags, tmo_set;
  logic gnt_valid, locked, own_sel, own_rel, tmo, flush_done;
  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_cl
    logic lock_wr;
    assign lock_wr = select_in[i] & wr_en_in[i] & (addr_in[i] == LOCK_ADDR);
    assign acq[i] = lock_wr & (data_in[i] == DATA_W'(CMD_ACQUIRE));
    assign rel[i] = lock_wr & (data_in[i] == DATA_W'(CMD_RELEASE));
    assign stat_wr[i] = select_in[i] & wr_en_in[i] & (addr_in[i] == STATUS_ADDR);
    assign data_out[i] = addr_in[i] == LOCK_ADDR ? DATA_W'(owner) :
                         addr_in[i] == STATUS_ADDR ? DATA_W'(tmo_flags) :
                         locked && owner == OW'(i) ? data_from_accel : '0;
  end
  rr_picker #(.N(N_CLIENTS)) u_pick (
    .req(acq),
    .last(last_owner),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );
  assign oi = owner[IW-1:0];
  assign locked = state == LOCKED;
  assign own_sel = locked & select_in[oi];
  assign own_rel = locked & rel[oi];
  // an owner release is itself an owner access, so it can never also count as a timeout
  assign tmo = TIMEOUT_CYC > 0 && locked && !own_sel && timer == 32'(TIMEOUT_CYC-1);
  assign tmo_set = tmo ? N_CLIENTS'(1) << oi : '0;
  assign flush_done = flush_cnt == FW'(RST_CYC-1);
  assign addr_o = locked ? addr_in[oi] : '0;
  assign wr_en_o = locked & wr_en_in[oi];
  assign accel_select_o = locked & select_in[oi];
  assign data_to_accel = locked & wr_en_in[oi] ? data_in[oi] : '0;
  assign owner_o = owner;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= FREE;
      last_owner <= IW'(N_CLIENTS-1);
      timer <= '0;
      tmo_flags <= '0;
      flush_cnt <= '0;
      accel_rst_o <= 1'b1;
    end else begin
      tmo_flags <= (tmo_flags & ~stat_wr) | tmo_set;
      case (state)
        IDLE: if (gnt_valid) begin
          state <= LOCKED;
          owner <= OW'(gnt_idx);
          timer <= '0;
          accel_rst_o <= 1'b0;
        end
        LOCKED: if (own_rel || tmo) begin
          state <= FLUSH;
          last_owner <= oi;
          owner <= FREE;
          flush_cnt <= '0;
          accel_rst_o <= 1'b1;
        end else timer <= own_sel ? '0 : timer + 32'd1;
        FLUSH: if (flush_done) begin
          state <= gnt_valid ? LOCKED : IDLE;
          owner <= gnt_valid ? OW'(gnt_idx) : FREE;
          timer <= '0;
          accel_rst_o <= 1'b0;
        end else flush_cnt <= flush_cnt + FW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_arbiter_rr.sv
// tb_lock_arbiter_rr: directed scoreboard bench for the round-robin accelerator lock
module tb_lock_arbiter_rr;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  logic [31:0] addr_in [N], data_in [N], data_out [N];
  logic wr_en_in [N], select_in [N];
  logic [31:0] data_from_accel, addr_o, data_to_accel;
  logic wr_en_o, accel_select_o, accel_rst_o;
  logic [2:0] owner_o;
  int n_checks = 0, n_fail = 0;
  string tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lock_arbiter_rr #(
    .N_CLIENTS(N), .ADDR_W(32), .DATA_W(32), .LOCK_ADDR(32'd84), .STATUS_ADDR(32'd88),
    .TIMEOUT_CYC(8), .RST_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .wr_en_in(wr_en_in), .select_in(select_in),
    .data_in(data_in), .data_out(data_out), .data_from_accel(data_from_accel),
    .addr_o(addr_o), .data_to_accel(data_to_accel), .wr_en_o(wr_en_o),
    .accel_select_o(accel_select_o), .accel_rst_o(accel_rst_o), .owner_o(owner_o)
  );

  task automatic clear_bus;
    for (int i = 0; i < N; i++) begin
      addr_in[i] = '0; data_in[i] = '0; wr_en_in[i] = 1'b0; select_in[i] = 1'b0;
    end
  endtask

  task automatic drive(input int c, input logic [31:0] a, input logic w, input logic [31:0] d);
    addr_in[c] = a; select_in[c] = 1'b1; wr_en_in[c] = w; data_in[c] = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h with no expectation queued", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, e);
    end
  endtask

  initial begin
    clear_bus;
    data_from_accel = 32'h55;
    rst = 1;
    repeat (2) tick;
    rst = 0;
    expect_v("rst_owner", 4); check(32'(owner_o));
    expect_v("rst_accel_rst", 1); check(32'(accel_rst_o));
    // value other than 0/1 on the lock register is ignored
    drive(0, 84, 1, 2); expect_v("ignored_cmd_owner", 4);
    tick; clear_bus; check(32'(owner_o));
    // client 0 acquires
    drive(0, 84, 1, 1); expect_v("acq0_owner", 0); expect_v("acq0_accel_rst", 0);
    tick; clear_bus; check(32'(owner_o)); check(32'(accel_rst_o));
    addr_in[2] = 84; #1; expect_v("lock_read_c2", 0); check(data_out[2]);
    // owner traffic passes through, non-owner traffic does not
    clear_bus; drive(0, 100, 1, 32'hAB); drive(1, 200, 1, 32'hCD); #1;
    expect_v("pass_addr", 100); check(addr_o);
    expect_v("pass_wr", 1); check(32'(wr_en_o));
    expect_v("pass_data", 32'hAB); check(data_to_accel);
    expect_v("pass_sel", 1); check(32'(accel_select_o));
    tick; clear_bus;
    drive(0, 100, 0, 0); drive(1, 100, 0, 0); #1;
    expect_v("owner_read", 32'h55); check(data_out[0]);
    expect_v("nonowner_read", 0); check(data_out[1]);
    tick; clear_bus;
    // non-owner release is ignored and never reaches the accelerator
    drive(1, 84, 1, 0); #1;
    expect_v("nonowner_wr_en", 0); check(32'(wr_en_o));
    expect_v("nonowner_sel", 0); check(32'(accel_select_o));
    expect_v("nonowner_rel_owner", 0);
    tick; clear_bus; check(32'(owner_o));
    // owner 0 releases; flush lasts 4 cycles
    drive(0, 84, 1, 0); expect_v("rel0_owner", 4); expect_v("flush1", 1);
    tick; clear_bus; check(32'(owner_o)); check(32'(accel_rst_o));
    drive(2, 84, 1, 1); expect_v("flush_drop_owner", 4); expect_v("flush2", 1);
    tick; clear_bus; check(32'(owner_o)); check(32'(accel_rst_o));
    expect_v("flush3", 1); tick; check(32'(accel_rst_o));
    expect_v("flush4", 1); tick; check(32'(accel_rst_o));
    drive(1, 84, 1, 1); expect_v("last_flush_grant", 1); expect_v("after_flush_rst", 0);
    tick; clear_bus; check(32'(owner_o)); check(32'(accel_rst_o));
    // last_owner=1, clients 0,2,3 request -> 2, then 0,3 -> 3
    drive(1, 84, 1, 0); tick; clear_bus; repeat (3) tick;
    drive(0, 84, 1, 1); drive(2, 84, 1, 1); drive(3, 84, 1, 1); expect_v("rr_grant2", 2);
    tick; clear_bus; check(32'(owner_o));
    drive(2, 84, 1, 0); tick; clear_bus; repeat (3) tick;
    drive(0, 84, 1, 1); drive(3, 84, 1, 1); expect_v("rr_grant3", 3);
    tick; clear_bus; check(32'(owner_o));
    // watchdog: owner 1 accesses once, then stays idle
    drive(3, 84, 1, 0); tick; clear_bus; repeat (3) tick;
    drive(1, 84, 1, 1); tick; clear_bus;
    repeat (5) tick;
    drive(1, 100, 0, 0); tick; clear_bus;
    repeat (7) tick;
    expect_v("lease_held", 1); check(32'(owner_o));
    tick;
    expect_v("lease_revoked", 4); check(32'(owner_o));
    expect_v("revoke_accel_rst", 1); check(32'(accel_rst_o));
    addr_in[0] = 88; #1; expect_v("status_b10", 2); check(data_out[0]);
    clear_bus; drive(0, 88, 1, 32'hFF); tick; clear_bus;
    addr_in[3] = 88; #1; expect_v("status_other_clear", 2); check(data_out[3]);
    clear_bus; drive(1, 88, 1, 32'h123); tick; clear_bus;
    addr_in[3] = 88; #1; expect_v("status_cleared", 0); check(data_out[3]);
    clear_bus; repeat (4) tick;
    expect_v("idle_accel_rst", 0); check(32'(accel_rst_o));
    // client 0 times out, re-acquires, then reset mid-lock
    drive(0, 84, 1, 1); tick; clear_bus;
    repeat (7) tick;
    expect_v("lease0_held", 0); check(32'(owner_o));
    tick;
    expect_v("lease0_revoked", 4); check(32'(owner_o));
    addr_in[0] = 88; #1; expect_v("status_b01", 1); check(data_out[0]);
    clear_bus; repeat (3) tick;
    drive(0, 84, 1, 1); expect_v("regrant0", 0);
    tick; clear_bus; check(32'(owner_o));
    rst = 1; expect_v("midrst_owner", 4); expect_v("midrst_accel_rst", 1);
    tick; rst = 0; check(32'(owner_o)); check(32'(accel_rst_o));
    addr_in[0] = 88; #1; expect_v("midrst_status", 0); check(data_out[0]);
    expect_v("midrst_accel_lock", 0); check(32'(wr_en_o));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
